k005297_tempdet_mc: RTL

Multi-channel, parametrised temperature-detect and heater controller for the 005297 bubble-memory controller. Per channel: debounce of the thermistor low-temperature input, a TEMPDROP set-pulse generator, and a heater-enable state machine. An optional heater-timeout fault is included. Sits between the board thermistor comparators and the controller's status/heater logic, clocked by the master clock and advanced only on the 4 MHz clock enable.

---
 rtl/k005297_tempdet_pkg.sv | 20 ++
 rtl/k005297_tempdet_mc_if.sv | 26 ++
 rtl/k005297_tempdet_ch.sv | 145 ++++++++++++++
 rtl/k005297_tempdet_mc.sv | 59 +++++
 4 files changed

// File: rtl/k005297_tempdet_pkg.sv
// Shared types and constants for the 005297 temperature-detect / heater controller.
package k005297_tempdet_pkg;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_HEAT  = 2'd1,
    HS_FAULT = 2'd2
  } heat_st_t;

  // Filtered TEMPLO and every edge-detect register come out of reset "high",
  // i.e. temperature OK and no pending edges.
  localparam logic FILT_RST = 1'b1;
  localparam logic EDGE_RST = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/k005297_tempdet_mc_if.sv
// Pin bundle between the board thermistor comparators / clock logic and the
// multi-channel temperature-detect block.
interface k005297_tempdet_mc_if #(
  parameter int CHANNELS = 2
);
  logic                i_CLK4M_PCEN_n;
  logic [CHANNELS-1:0] i_TEMPLO_n;
  logic                i_CLK2M_STOP_n;
  logic                i_CLK2M_STOP_DLYD_n;
  logic                i_FAULT_CLR;

  logic [CHANNELS-1:0] o_TEMPDROP_SET_n;
  logic [CHANNELS-1:0] o_HEATEN_n;
  logic                o_TEMPOK;
  logic [CHANNELS-1:0] o_FAULT;

  modport master (
    output i_CLK4M_PCEN_n, i_TEMPLO_n, i_CLK2M_STOP_n, i_CLK2M_STOP_DLYD_n, i_FAULT_CLR,
    input  o_TEMPDROP_SET_n, o_HEATEN_n, o_TEMPOK, o_FAULT
  );

  modport slave (
    input  i_CLK4M_PCEN_n, i_TEMPLO_n, i_CLK2M_STOP_n, i_CLK2M_STOP_DLYD_n, i_FAULT_CLR,
    output o_TEMPDROP_SET_n, o_HEATEN_n, o_TEMPOK, o_FAULT
  );
endinterface

// File: rtl/k005297_tempdet_ch.sv
// One temperature channel: TEMPLO sync + debounce, TEMPDROP edge pulse, heater FSM.
// Heater timeout (hcnt / FAULT) exists only when K005297_TEMPDET_HEAT_TIMEOUT_EN is defined.
module k005297_tempdet_ch
  import k005297_tempdet_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int HEAT_MAX = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic templo_n,
  input  logic clk2m_stop_n,
  input  logic clk2m_stop_dlyd_n,
  input  logic fault_clr,
  output logic tempdrop_set_n,
  output logic heaten_n,
  output logic fault,
  output logic filt
);

  localparam int                FCNT_W    = cnt_w(FILT_LEN);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);

  logic              raw_q, raw_d;
  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              g_q, g_d;
  logic              dly_q, dly_d;
  heat_st_t          state_q, state_d;
  logic              heaten_n_q, heaten_n_d;

  logic g, set_ev, clr_ev;
  logic timeout, fault_clr_en;

  assign g      = clk2m_stop_n & filt_q;
  assign set_ev = ~dly_q & clk2m_stop_dlyd_n & ~filt_q;
  assign clr_ev = (~g_q & g) | ~clk2m_stop_n;

  // g_q still holds the pre-drop value for exactly one tick after filt falls.
  assign tempdrop_set_n = ~(g_q & ~g);
  assign heaten_n       = heaten_n_q;
  assign filt           = filt_q;

  // Stage: input sync, debounce and edge registers
  always_comb begin
    raw_d  = raw_q;
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    g_d    = g_q;
    dly_d  = dly_q;
    if (tick) begin
      raw_d = templo_n;
      g_d   = g;
      dly_d = clk2m_stop_dlyd_n;
      if (raw_q == filt_q) begin
        fcnt_d = '0;
      end else if (fcnt_q == FCNT_LAST) begin
        filt_d = raw_q;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  // Stage: heater state machine; a clear event always beats a set or a timeout
  always_comb begin
    state_d    = state_q;
    heaten_n_d = heaten_n_q;
    if (tick) begin
      heaten_n_d = (state_q != HS_HEAT);
      case (state_q)
        HS_IDLE:  if (set_ev && !clr_ev) state_d = HS_HEAT;
        HS_HEAT: begin
          if (clr_ev)       state_d = HS_IDLE;
          else if (timeout) state_d = HS_FAULT;
        end
        HS_FAULT: if (fault_clr_en) state_d = HS_IDLE;
        default:  state_d = HS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q      <= EDGE_RST;
      filt_q     <= FILT_RST;
      fcnt_q     <= '0;
      g_q        <= EDGE_RST;
      dly_q      <= EDGE_RST;
      state_q    <= HS_IDLE;
      heaten_n_q <= 1'b1;
    end else begin
      raw_q      <= raw_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      g_q        <= g_d;
      dly_q      <= dly_d;
      state_q    <= state_d;
      heaten_n_q <= heaten_n_d;
    end
  end

`ifdef K005297_TEMPDET_HEAT_TIMEOUT_EN
  localparam int                HCNT_W   = cnt_w(HEAT_MAX + 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HEAT_MAX);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              fault_q, fault_d;

  assign timeout      = (hcnt_q == HCNT_MAX);
  assign fault_clr_en = fault_clr;
  assign fault        = fault_q;

  // Held at zero outside HEAT, so it always starts from zero on entry.
  always_comb begin
    hcnt_d  = hcnt_q;
    fault_d = fault_q;
    if (tick) begin
      fault_d = (state_q == HS_FAULT);
      if (state_q != HS_HEAT)     hcnt_d = '0;
      else if (hcnt_q != HCNT_MAX) hcnt_d = hcnt_q + HCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      fault_q <= fault_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign fault_clr_en       = 1'b0;
  assign fault              = 1'b0;
  assign unused_timeout_cfg = fault_clr ^ (HEAT_MAX == 0);
`endif

endmodule

// File: rtl/k005297_tempdet_mc.sv
// Multi-channel temperature detect / heater controller for the 005297.
// Optional heater timeout fault: define K005297_TEMPDET_HEAT_TIMEOUT_EN.
module k005297_tempdet_mc
  import k005297_tempdet_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int FILT_LEN = 8,
  parameter int HEAT_MAX = 4095
) (
  input  logic                 i_MCLK,
  input  logic                 i_RST,
  k005297_tempdet_mc_if.slave  bus
);

  logic                tick;
  logic [CHANNELS-1:0] filt;
  logic [CHANNELS-1:0] drop_n;
  logic [CHANNELS-1:0] heaten_n;
  logic [CHANNELS-1:0] fault;
  logic                tempok_q, tempok_d;

  assign tick = ~bus.i_CLK4M_PCEN_n;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    k005297_tempdet_ch #(
      .FILT_LEN (FILT_LEN),
      .HEAT_MAX (HEAT_MAX)
    ) u_ch (
      .clk               (i_MCLK),
      .rst               (i_RST),
      .tick              (tick),
      .templo_n          (bus.i_TEMPLO_n[c]),
      .clk2m_stop_n      (bus.i_CLK2M_STOP_n),
      .clk2m_stop_dlyd_n (bus.i_CLK2M_STOP_DLYD_n),
      .fault_clr         (bus.i_FAULT_CLR),
      .tempdrop_set_n    (drop_n[c]),
      .heaten_n          (heaten_n[c]),
      .fault             (fault[c]),
      .filt              (filt[c])
    );
  end

  // Stage: module-wide temperature OK
  always_comb begin
    tempok_d = tempok_q;
    if (tick) tempok_d = &filt;
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) tempok_q <= FILT_RST;
    else       tempok_q <= tempok_d;
  end

  assign bus.o_TEMPDROP_SET_n = drop_n;
  assign bus.o_HEATEN_n       = heaten_n;
  assign bus.o_FAULT          = fault;
  assign bus.o_TEMPOK         = tempok_q;

endmodule
